// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling 7-segment message display.
package scroll_pkg;

    // Character codes beyond the hex digits 0-15
    localparam logic [4:0] CH_H     = 5'd16;
    localparam logic [4:0] CH_L     = 5'd17;
    localparam logic [4:0] CH_P     = 5'd18;
    localparam logic [4:0] CH_U     = 5'd19;
    localparam logic [4:0] CH_DASH  = 5'd20;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Active-low: all segments / all anodes off
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/scroll_display_seg7_decode.sv
// Character code to active-low 7-segment pattern, bit 0 = a ... bit 6 = g.
module seg7_decode
    import scroll_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Pure lookup; unknown codes (21-31) blank the digit
    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            CH_H:    seg = 7'h09;
            CH_L:    seg = 7'h47;
            CH_P:    seg = 7'h0C;
            CH_U:    seg = 7'h41;
            CH_DASH: seg = 7'h3F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/scroll_display.sv
// Scrolls a 4-digit window over a writable message buffer and multiplexes
// the window onto a common-anode 7-segment display, one digit per tick.
module scroll_display
    import scroll_pkg::*;
#(
    parameter int MSG_LEN    = 16,
    parameter int SCROLL_DIV = 50
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [AW:0]   LEN_EXT  = (AW+1)'(MSG_LEN);
    localparam logic [AW-1:0] POS_LAST = AW'(MSG_LEN - 1);
    localparam logic [SW-1:0] DIV_LAST = SW'(SCROLL_DIV - 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           pos_q, pos_d;
    logic [1:0]              dsel_q, dsel_d;
    logic [SW-1:0]           sdiv_q, sdiv_d;
    logic [MSG_LEN-1:0][4:0] msg_q, msg_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;

    logic [AW:0]   idx_sum;
    logic [AW-1:0] rd_idx;
    logic [4:0]    cur_char;
    logic [6:0]    dec_seg;

    // Next state, digit select and scroll position
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dsel_d  = dsel_q;
        sdiv_d  = sdiv_q;
        unique case (state_q)
            IDLE: begin
                pos_d  = '0;
                dsel_d = '0;
                sdiv_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    dsel_d = (dsel_q == 2'd3) ? 2'd0 : dsel_q + 2'd1;
                    // A tick that coincides with pause only moves the digit mux
                    if (!pause) begin
                        if (sdiv_q == DIV_LAST) begin
                            sdiv_d = '0;
                            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + AW'(1);
                        end else begin
                            sdiv_d = sdiv_q + SW'(1);
                        end
                    end
                end
                if (pause) state_d = HOLD;
            end
            HOLD: begin
                if (tick) dsel_d = (dsel_q == 2'd3) ? 2'd0 : dsel_q + 2'd1;
                if (!pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer write port; addresses past the end are dropped
    always_comb begin
        msg_d = msg_q;
        if (wr_en && ({27'd0, wr_addr} < 32'(MSG_LEN)))
            msg_d[wr_addr[AW-1:0]] = wr_data;
    end

    // Window read index (pos + dsel) mod MSG_LEN; MSG_LEN need not be a power of 2
    always_comb begin
        idx_sum = {1'b0, pos_q} + {{(AW-1){1'b0}}, dsel_q};
        rd_idx  = (idx_sum >= LEN_EXT) ? AW'(idx_sum - LEN_EXT) : idx_sum[AW-1:0];
        cur_char = msg_q[rd_idx];
    end

    seg7_decode u_dec (
        .code (cur_char),
        .seg  (dec_seg)
    );

    // Pin values for next cycle; blanked while idle
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (state_q != IDLE) begin
            seg_d = dec_seg;
            an_d  = ~(4'b1000 >> dsel_q);
        end
    end

    // All state and registered outputs
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            dsel_q  <= '0;
            sdiv_q  <= '0;
            msg_q   <= {MSG_LEN{CH_BLANK}};
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dsel_q  <= dsel_d;
            sdiv_q  <= sdiv_d;
            msg_q   <= msg_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
